// File: rtl/sc64_pkg.sv
// Shared SC64 definitions: N64 bus target ids, router state encoding and
// the error word returned by the bus router.
package sc64;

    // N64 internal bus target ids. Only the first five are routable today;
    // the remaining codes are named so that every 3-bit value is a member.
    typedef enum logic [2:0] {
        ID_N64_SDRAM      = 3'd0,
        ID_N64_BOOTLOADER = 3'd1,
        ID_N64_FLASHRAM   = 3'd2,
        ID_N64_CONFIG     = 3'd3,
        ID_N64_DD_REGS    = 3'd4,
        ID_N64_RSVD_5     = 3'd5,
        ID_N64_RSVD_6     = 3'd6,
        ID_N64_RSVD_7     = 3'd7
    } e_n64_id;

    // Bus router transaction state.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } e_router_state;

    // Read data returned for invalid, disabled or timed-out transactions.
    localparam logic [15:0] ROUTER_ERROR_DATA = 16'hFFFF;

endpackage

// File: rtl/n64_bus_watchdog.sv
// Per-transaction watchdog: counts enabled cycles from zero and flags
// expiry when the count reaches TIMEOUT-1. Clear has priority over enable.
module n64_bus_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] count;

    // Cycle counter: cleared between transactions, advanced while waiting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/n64_bus_router.sv
// Routes single-master N64 bus transactions to one of NUM_TARGETS slaves and
// returns the slave's response; a watchdog answers hung slaves with an error.
//
// Handshake: the master raises n64_request with id/write/address/wdata and
// holds it until it sees the one-cycle n64_ack pulse, then drops it one cycle
// later. Toward the slaves, tgt_request stays high (one-hot) with stable
// tgt_* fields until the selected slave pulses its tgt_ack bit.
module n64_bus_router
    import sc64::*;
#(
    parameter int          NUM_TARGETS = 5,
    parameter int          TIMEOUT     = 1024,
    parameter logic [15:0] ERROR_DATA  = ROUTER_ERROR_DATA
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      abort,
    input  logic [NUM_TARGETS-1:0]    target_enable,
    input  logic                      n64_request,
    input  logic                      n64_write,
    input  e_n64_id                   n64_id,
    input  logic [31:0]               n64_address,
    input  logic [15:0]               n64_wdata,
    output logic                      n64_ack,
    output logic [15:0]               n64_rdata,
    output logic [NUM_TARGETS-1:0]    tgt_request,
    output logic                      tgt_write,
    output logic [31:0]               tgt_address,
    output logic [15:0]               tgt_wdata,
    input  logic [NUM_TARGETS-1:0]    tgt_ack,
    input  logic [16*NUM_TARGETS-1:0] tgt_rdata,
    output logic [15:0]               timeout_count,
    input  logic                      timeout_clear
);

    e_router_state          state;
    logic [2:0]             sel;
    logic [2:0]             id_raw;
    logic [NUM_TARGETS-1:0] id_onehot;
    logic                   id_ok;
    logic                   sel_ack;
    logic [15:0]            sel_rdata;
    logic                   wd_expired;
    logic                   timeout_hit;

    assign id_raw = n64_id;

    // Decode the incoming id and mux the selected slave's ack/rdata.
    always_comb begin
        id_onehot = '0;
        sel_ack   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            if (id_raw == 3'(i)) begin
                id_onehot[i] = target_enable[i];
            end
            if (sel == 3'(i)) begin
                sel_ack   = tgt_ack[i];
                sel_rdata = tgt_rdata[16*i +: 16];
            end
        end
        id_ok = |id_onehot;
    end

    n64_bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (state != ST_BUSY),
        .enable  ((state == ST_BUSY) && !sel_ack),
        .expired (wd_expired)
    );

    // A slave ack on the expiry cycle wins, so it is not a timeout.
    assign timeout_hit = (state == ST_BUSY) && !sel_ack && wd_expired && !abort;

    // Transaction FSM: accept in IDLE, wait for ack/expiry in BUSY, and let
    // the master drop its request during the single DONE cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            sel         <= '0;
            n64_ack     <= 1'b0;
            n64_rdata   <= '0;
            tgt_request <= '0;
            tgt_write   <= 1'b0;
            tgt_address <= '0;
            tgt_wdata   <= '0;
        end else if (abort) begin
            state       <= ST_IDLE;
            n64_ack     <= 1'b0;
            tgt_request <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    n64_ack <= 1'b0;
                    if (n64_request) begin
                        sel         <= id_raw;
                        tgt_write   <= n64_write;
                        tgt_address <= n64_address;
                        tgt_wdata   <= n64_wdata;
                        if (id_ok) begin
                            tgt_request <= id_onehot;
                            state       <= ST_BUSY;
                        end else begin
                            n64_ack   <= 1'b1;
                            n64_rdata <= ERROR_DATA;
                            state     <= ST_DONE;
                        end
                    end
                end
                ST_BUSY: begin
                    if (sel_ack) begin
                        tgt_request <= '0;
                        n64_ack     <= 1'b1;
                        n64_rdata   <= sel_rdata;
                        state       <= ST_DONE;
                    end else if (wd_expired) begin
                        tgt_request <= '0;
                        n64_ack     <= 1'b1;
                        n64_rdata   <= ERROR_DATA;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    n64_ack <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    n64_ack     <= 1'b0;
                    tgt_request <= '0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

    // Saturating timeout statistics; clear beats a simultaneous increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_count <= '0;
        end else if (timeout_clear) begin
            timeout_count <= '0;
        end else if (timeout_hit && (timeout_count != 16'hFFFF)) begin
            timeout_count <= timeout_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_n64_bus_router.sv
// Directed bench for n64_bus_router with a short watchdog (TIMEOUT=16).
module tb_n64_bus_router;
    import sc64::*;

    localparam int NT = 5;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          abort;
    logic [NT-1:0] target_enable;
    logic          n64_request;
    logic          n64_write;
    e_n64_id       n64_id;
    logic [31:0]   n64_address;
    logic [15:0]   n64_wdata;
    logic          n64_ack;
    logic [15:0]   n64_rdata;
    logic [NT-1:0] tgt_request;
    logic          tgt_write;
    logic [31:0]   tgt_address;
    logic [15:0]   tgt_wdata;
    logic [NT-1:0] tgt_ack;
    logic [16*NT-1:0] tgt_rdata;
    logic [15:0]   timeout_count;
    logic          timeout_clear;

    int n_cmp = 0;
    int n_bad = 0;
    int ack_cnt = 0;
    logic prev_ack = 1'b0;
    logic mon_on = 1'b0;

    n64_bus_router #(
        .NUM_TARGETS (NT),
        .TIMEOUT     (TO),
        .ERROR_DATA  (16'hFFFF)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .abort         (abort),
        .target_enable (target_enable),
        .n64_request   (n64_request),
        .n64_write     (n64_write),
        .n64_id        (n64_id),
        .n64_address   (n64_address),
        .n64_wdata     (n64_wdata),
        .n64_ack       (n64_ack),
        .n64_rdata     (n64_rdata),
        .tgt_request   (tgt_request),
        .tgt_write     (tgt_write),
        .tgt_address   (tgt_address),
        .tgt_wdata     (tgt_wdata),
        .tgt_ack       (tgt_ack),
        .tgt_rdata     (tgt_rdata),
        .timeout_count (timeout_count),
        .timeout_clear (timeout_clear)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled at negedge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic [2:0] id, input logic wr, input logic [31:0] addr,
                         input logic [15:0] wd);
        n64_id      = e_n64_id'(id);
        n64_write   = wr;
        n64_address = addr;
        n64_wdata   = wd;
        n64_request = 1'b1;
    endtask

    // Invariant monitor: one-hot slave request, ack never two cycles in a row.
    always @(negedge clk) begin
        if (mon_on) begin
            check_eq("onehot", {31'b0, $countones(tgt_request) <= 1}, 32'd1);
            check_eq("ack_pulse", {31'b0, prev_ack & n64_ack}, 32'd0);
            prev_ack = n64_ack;
            if (n64_ack) ack_cnt++;
        end
    end

    initial begin
        reset = 1'b1; abort = 1'b0; target_enable = '1; n64_request = 1'b0;
        n64_write = 1'b0; n64_id = ID_N64_SDRAM; n64_address = '0; n64_wdata = '0;
        tgt_ack = '0; timeout_clear = 1'b0;
        tgt_rdata = {16'h4444, 16'h3C3C, 16'h2222, 16'h1111, 16'hA5A5};
        tgt_rdata[16*4 +: 16] = 16'h0F0F;
        repeat (2) @(negedge clk);

        // Reset values
        check_eq("rst_ack", {31'b0, n64_ack}, 0);
        check_eq("rst_rdata", {16'b0, n64_rdata}, 0);
        check_eq("rst_treq", {27'b0, tgt_request}, 0);
        check_eq("rst_twr", {31'b0, tgt_write}, 0);
        check_eq("rst_taddr", tgt_address, 0);
        check_eq("rst_twd", {16'b0, tgt_wdata}, 0);
        check_eq("rst_tocnt", {16'b0, timeout_count}, 0);
        reset = 1'b0;
        mon_on = 1'b1;
        step();

        // SDRAM read, slave acks 3 cycles after tgt_request rises
        issue(3'd0, 1'b0, 32'h1000_0000, 16'h0000);
        step();                                      // cycle 1
        check_eq("rd_treq_c1", {27'b0, tgt_request}, 32'h01);
        check_eq("rd_taddr", tgt_address, 32'h1000_0000);
        check_eq("rd_twr", {31'b0, tgt_write}, 0);
        check_eq("rd_ack_c1", {31'b0, n64_ack}, 0);
        step();                                      // cycle 2
        check_eq("rd_treq_c2", {27'b0, tgt_request}, 32'h01);
        step();                                      // cycle 3
        check_eq("rd_treq_c3", {27'b0, tgt_request}, 32'h01);
        step();                                      // cycle 4
        check_eq("rd_treq_c4", {27'b0, tgt_request}, 32'h01);
        check_eq("rd_ack_c4", {31'b0, n64_ack}, 0);
        tgt_ack = 5'b00001;
        step();                                      // cycle 5
        tgt_ack = '0;
        check_eq("rd_ack_c5", {31'b0, n64_ack}, 1);
        check_eq("rd_rdata", {16'b0, n64_rdata}, 32'hA5A5);
        check_eq("rd_treq_c5", {27'b0, tgt_request}, 0);
        step();                                      // DONE ignored held request
        n64_request = 1'b0;
        check_eq("rd_done_ack", {31'b0, n64_ack}, 0);
        check_eq("rd_hold_rdata", {16'b0, n64_rdata}, 32'hA5A5);
        check_eq("rd_no_reissue", {27'b0, tgt_request}, 0);
        step();

        // Invalid id 7 write
        issue(3'd7, 1'b1, 32'h0000_0040, 16'h1234);
        step();
        check_eq("inv_ack", {31'b0, n64_ack}, 1);
        check_eq("inv_rdata", {16'b0, n64_rdata}, 32'hFFFF);
        check_eq("inv_treq", {27'b0, tgt_request}, 0);
        check_eq("inv_twd", {16'b0, tgt_wdata}, 32'h1234);
        step();
        n64_request = 1'b0;
        check_eq("inv_done_ack", {31'b0, n64_ack}, 0);
        check_eq("inv_treq2", {27'b0, tgt_request}, 0);
        step();

        // Disabled target (bootloader)
        target_enable = 5'b11101;
        issue(3'd1, 1'b0, 32'h0000_0100, 16'h0000);
        step();
        check_eq("dis_ack", {31'b0, n64_ack}, 1);
        check_eq("dis_rdata", {16'b0, n64_rdata}, 32'hFFFF);
        check_eq("dis_treq", {27'b0, tgt_request}, 0);
        step();
        n64_request = 1'b0;
        target_enable = '1;
        step();

        // Timeout on flashram; stray ack from slave 0 mid-BUSY is ignored
        issue(3'd2, 1'b0, 32'h0800_0000, 16'h0000);
        step();                                      // cycle 1
        for (int c = 1; c < TO; c++) begin
            check_eq("to_wait_ack", {31'b0, n64_ack}, 0);
            tgt_ack = (c == 5) ? 5'b00001 : 5'b00000;
            step();
        end
        tgt_ack = '0;                                // cycle 16
        check_eq("to_treq_c16", {27'b0, tgt_request}, 32'h04);
        check_eq("to_ack_c16", {31'b0, n64_ack}, 0);
        step();                                      // cycle 17
        check_eq("to_ack_c17", {31'b0, n64_ack}, 1);
        check_eq("to_rdata", {16'b0, n64_rdata}, 32'hFFFF);
        check_eq("to_treq_c17", {27'b0, tgt_request}, 0);
        check_eq("to_cnt1", {16'b0, timeout_count}, 1);
        step();
        n64_request = 1'b0;
        step();

        // Slave ack on the expiry cycle wins
        issue(3'd3, 1'b0, 32'h1FFC_0000, 16'h0000);
        step();                                      // cycle 1
        repeat (TO - 1) step();                      // cycle 16
        check_eq("exp_ack_c16", {31'b0, n64_ack}, 0);
        tgt_ack = 5'b01000;
        step();                                      // cycle 17
        tgt_ack = '0;
        check_eq("exp_ack_c17", {31'b0, n64_ack}, 1);
        check_eq("exp_rdata", {16'b0, n64_rdata}, 32'h3C3C);
        check_eq("exp_cnt", {16'b0, timeout_count}, 1);
        step();
        n64_request = 1'b0;
        step();

        // timeout_clear
        timeout_clear = 1'b1;
        step();
        timeout_clear = 1'b0;
        check_eq("to_clear", {16'b0, timeout_count}, 0);

        // Abort two cycles into BUSY, then a fresh request
        issue(3'd4, 1'b0, 32'h0500_0000, 16'h0000);
        step();                                      // cycle 1
        check_eq("ab_treq_c1", {27'b0, tgt_request}, 32'h10);
        step();                                      // cycle 2
        abort = 1'b1;
        step();
        abort = 1'b0;
        n64_request = 1'b0;
        check_eq("ab_treq", {27'b0, tgt_request}, 0);
        check_eq("ab_ack", {31'b0, n64_ack}, 0);
        step();
        check_eq("ab_ack2", {31'b0, n64_ack}, 0);
        check_eq("ab_cnt", {16'b0, timeout_count}, 0);
        issue(3'd4, 1'b1, 32'h0500_0002, 16'hBEEF);
        step();                                      // cycle 1
        check_eq("fr_treq", {27'b0, tgt_request}, 32'h10);
        check_eq("fr_twd", {16'b0, tgt_wdata}, 32'hBEEF);
        check_eq("fr_twr", {31'b0, tgt_write}, 1);
        tgt_ack = 5'b10000;
        step();
        tgt_ack = '0;
        check_eq("fr_ack", {31'b0, n64_ack}, 1);
        check_eq("fr_rdata", {16'b0, n64_rdata}, 32'h0F0F);
        step();
        n64_request = 1'b0;
        step();
        step();

        check_eq("ack_total", ack_cnt, 6);
        mon_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/n64_bus_router.md
Name: n64_bus_router

Overview:
- Sits directly downstream of the N64 PI front-end.
- Takes its single-master internal bus transaction (request/id/address/write/wdata) and routes it to exactly one of NUM_TARGETS slaves: SDRAM, bootloader, flashram, config, DD regs.
- Returns that slave's ack/rdata to the master.
- Adds a per-transaction watchdog: a hung or disabled slave is answered with an error word, so the PI never stalls.

Parameters:
- NUM_TARGETS, 5, number of slave ports; id values 0..NUM_TARGETS-1 are routable.
- TIMEOUT, 1024, BUSY cycles without slave ack before a forced error response; must be at least 2.
- ERROR_DATA, 16'hFFFF, rdata returned on invalid, disabled or timed-out transactions.

Ports:
- clk  in  1  system clock (sys.clk)
- reset  in  1  asynchronous, active-high reset (sys.reset)
- abort  in  1  synchronous transaction abort (N64 soft/hard reset)
- target_enable  in  NUM_TARGETS  per-target enable mask
- n64_request  in  1  master request, held until ack seen
- n64_write  in  1  1 = write, 0 = read
- n64_id  in  3  target id (sc64::e_n64_id)
- n64_address  in  32  byte address
- n64_wdata  in  16  write data
- n64_ack  out  1  one-cycle completion pulse
- n64_rdata  out  16  read data, valid while n64_ack is high
- tgt_request  out  NUM_TARGETS  one-hot slave request
- tgt_write  out  1  latched write flag
- tgt_address  out  32  latched address
- tgt_wdata  out  16  latched write data
- tgt_ack  in  NUM_TARGETS  slave ack pulses
- tgt_rdata  in  16*NUM_TARGETS  slave read data; slave i occupies bits [16i+15:16i]
- timeout_count  out  16  saturating count of timed-out transactions
- timeout_clear  in  1  synchronous clear of timeout_count

Behaviour:
- Reset (async) values:
  - state = IDLE; n64_ack = 0; n64_rdata = 0.
  - tgt_request = 0; tgt_write = 0; tgt_address = 0; tgt_wdata = 0.
  - timeout_count = 0; internal select and watchdog counter = 0.
- States: IDLE, BUSY, DONE.
- IDLE, when n64_request is high (cycle 0):
  - Latch id, write, address and wdata into the select register and tgt_* outputs.
  - If id < NUM_TARGETS and target_enable[id] is set: tgt_request[id] = 1 from cycle 1, watchdog counter = 0, go to BUSY.
  - Otherwise: n64_ack = 1 and n64_rdata = ERROR_DATA at cycle 1, write discarded, go to DONE.
- BUSY:
  - tgt_request stays one-hot on the selected slave and tgt_* outputs are stable.
  - Slave ack: if tgt_ack[sel] is high at cycle n, then tgt_request = 0, n64_ack = 1 and n64_rdata = tgt_rdata[sel] at cycle n+1; go to DONE. This applies to writes too; the master ignores rdata on writes.
  - No ack: the counter increments.
  - Timeout: if the counter equals TIMEOUT-1 with no ack, then tgt_request = 0, n64_ack = 1, n64_rdata = ERROR_DATA and timeout_count increments (saturating at 16'hFFFF); go to DONE.
  - Forced error ack therefore appears TIMEOUT+1 cycles after the request.
  - Ack and timeout in the same cycle: ack wins, no timeout is counted.
  - Acks from non-selected slaves are ignored in every state.
- DONE:
  - n64_ack = 0; n64_rdata holds its value.
  - n64_request is ignored for this one cycle, because the master drops request one cycle after seeing ack.
  - Next state is IDLE.
- abort:
  - Any state goes to IDLE next cycle with tgt_request = 0 and n64_ack = 0; no response is issued.
  - timeout_count is unaffected.
  - abort wins over every simultaneous event.
- timeout_clear:
  - Forces timeout_count to 0.
  - Wins over a simultaneous increment.
- target_enable is sampled only in IDLE. Disabling a target mid-transaction does not cancel it.
- Invariants:
  - tgt_request has at most one bit set.
  - n64_ack is never high on two consecutive cycles.

Decomposition:
- Shared package sc64:
  - e_n64_id already exists there and is reused for n64_id.
  - Add the ROUTER_ERROR_DATA constant.
  - Add the router state enum e_router_state.
- Sub-module n64_bus_watchdog:
  - Function: a loadable counter with clear, enable and an expiry output at TIMEOUT-1.
  - Reuse: usable by future bus masters.

Test Plan:
- Read, id=SDRAM (0), address 32'h1000_0000; slave acks 3 cycles after tgt_request rises with rdata 16'hA5A5 -> n64_ack 1 cycle later, n64_rdata 16'hA5A5, tgt_request one-hot 5'b00001 throughout.
- Write, id 7 (invalid) or target_enable=0 -> n64_ack at cycle 1, rdata 16'hFFFF, tgt_request never asserted.
- TIMEOUT=16, slave never acks -> n64_ack at cycle 17, rdata 16'hFFFF, timeout_count 0->1; after timeout_clear -> 0.
- Slave ack on exactly the expiry cycle -> slave rdata returned, timeout_count unchanged.
- abort 2 cycles into BUSY -> tgt_request drops next cycle, no n64_ack; a fresh request is then served normally.
- Back-to-back: master holds request one cycle after ack, then issues a new request -> exactly one ack per transaction; a non-selected tgt_ack pulse injected mid-BUSY is ignored.
